// File: rtl/flash_read_ctrl.sv
// SPI NOR read controller: issues 0x03 + 24-bit address, returns one 32-bit word.
// SPI mode 0; data bytes are packed little-endian into resp_data.
module flash_read_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        busy,
    output logic        spi_sck,
    output logic        spi_ss,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int GAP_W = $clog2(CS_GAP + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        RESP,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bit_q, bit_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [31:0]      tx_q, tx_d;
    logic [31:0]      rx_q, rx_d;
    logic [31:0]      data_q, data_d;
    logic             sck_q, sck_d;
    logic             ss_q, ss_d;
    logic             mosi_q, mosi_d;
    logic             rvalid_q, rvalid_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             half_end;
    logic             last_bit;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        data_d   = data_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        half_end = (div_q == DIV_LAST);
        last_bit = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    state_d = CMD;
                    tx_d    = {8'h03, req_addr};
                    rx_d    = '0;
                    div_d   = '0;
                    bit_d   = '0;
                    gap_d   = '0;
                    sck_d   = 1'b0;
                    mosi_d  = tx_d[31];
                end
            end
            CMD, ADDR, DATA: begin
                last_bit = (state_q == CMD  && bit_q == 5'd7)
                        || (state_q == ADDR && bit_q == 5'd23)
                        || (state_q == DATA && bit_q == 5'd31);
                if (!half_end) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        if (state_q == DATA) begin
                            rx_d = {rx_q[30:0], spi_miso};
                        end
                    end else begin
                        // end of bit period: next bit goes out while sck falls
                        sck_d = 1'b0;
                        tx_d  = {tx_q[30:0], 1'b0};
                        if (last_bit) begin
                            bit_d = '0;
                            if (state_q == CMD) begin
                                state_d = ADDR;
                            end else if (state_q == ADDR) begin
                                state_d = DATA;
                            end else begin
                                state_d = RESP;
                                data_d  = {rx_q[7:0], rx_q[15:8],
                                           rx_q[23:16], rx_q[31:24]};
                            end
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                        mosi_d = (state_d == CMD || state_d == ADDR)
                               ? tx_d[31] : 1'b0;
                    end
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = GAP;
                    gap_d   = '0;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ss_d     = !(state_d inside {CMD, ADDR, DATA});
        rvalid_d = (state_d == RESP);
        ready_d  = (state_d == IDLE);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            data_q   <= '0;
            sck_q    <= 1'b0;
            ss_q     <= 1'b1;
            mosi_q   <= 1'b0;
            rvalid_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            gap_q    <= gap_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            data_q   <= data_d;
            sck_q    <= sck_d;
            ss_q     <= ss_d;
            mosi_q   <= mosi_d;
            rvalid_q <= rvalid_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = rvalid_q;
    assign resp_data  = data_q;
    assign busy       = busy_q;
    assign spi_sck    = sck_q;
    assign spi_ss     = ss_q;
    assign spi_mosi   = mosi_q;

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Bench for flash_read_ctrl: behavioural SPI flash, pin monitor and
// transaction-level expectations derived from the read protocol.
module tb_flash_read_ctrl;
    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        busy;
    logic        spi_sck;
    logic        spi_ss;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int n_chk = 0;
    int n_pass = 0;
    int early_acc = 0;

    flash_read_ctrl #(
        .CLK_DIV(CLK_DIV),
        .CS_GAP (CS_GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .busy      (busy),
        .spi_sck   (spi_sck),
        .spi_ss    (spi_ss),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Behavioural flash: captures cmd+addr on sck rise, shifts bytes out on sck fall
    logic [7:0]  fq[$];
    logic [31:0] capq[$];
    logic [31:0] cap = '0;
    logic [7:0]  cur_b = '0;
    int          rise_n = 0;
    logic        f_ss = 1'b1;
    logic        f_sck = 1'b0;

    always @(spi_ss or spi_sck) begin
        int i;
        if (spi_ss !== f_ss) begin
            if (spi_ss === 1'b0) begin
                rise_n   = 0;
                cap      = '0;
                spi_miso = 1'b0;
            end else if (rise_n >= 32) begin
                capq.push_back(cap);
                rise_n = 0;
            end
        end
        if (spi_sck !== f_sck && spi_ss === 1'b0) begin
            if (spi_sck === 1'b1) begin
                if (rise_n < 32) cap = {cap[30:0], spi_mosi};
                rise_n++;
            end else if (rise_n >= 32 && rise_n < 64) begin
                i = rise_n - 32;
                if (i % 8 == 0) cur_b = (fq.size() > 0) ? fq.pop_front() : 8'h00;
                spi_miso = cur_b[7 - (i % 8)];
            end
        end
        f_ss  = spi_ss;
        f_sck = spi_sck;
    end

    // Pin monitor sampled on the falling clk edge
    int   cyc = 0, hi_run = 0, last_hi = 0, rises = 0, last_rise = -1;
    int   sck_bad = 0, mosi_bad = 0, win_bad = 0, ss_bad = 0;
    logic p_ss = 1'b1, p_sck = 1'b0, p_mosi = 1'b0;
    bit   had_txn = 0, in_win = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hi_run = 0; rises = 0; last_rise = -1;
            had_txn = 0; in_win = 0;
            p_ss = 1'b1; p_sck = 1'b0; p_mosi = 1'b0;
        end else begin
            cyc++;
            if (spi_ss) begin
                if (!p_ss && in_win) begin
                    if (rises != 64) win_bad++;
                    in_win = 0;
                end
                if (spi_sck || spi_mosi) mosi_bad++;
                hi_run++;
            end else begin
                if (p_ss) begin
                    if (had_txn && hi_run < CS_GAP + 2) ss_bad++;
                    last_hi = hi_run;
                    had_txn = 1; in_win = 1;
                    rises = 0; last_rise = -1; hi_run = 0;
                end else if (spi_mosi !== p_mosi && !(p_sck && !spi_sck)) begin
                    mosi_bad++;
                end
                if (!p_sck && spi_sck) begin
                    rises++;
                    if (last_rise >= 0 && cyc - last_rise != 2 * CLK_DIV) sck_bad++;
                    last_rise = cyc;
                    if (rises > 32 && spi_mosi) mosi_bad++;
                end
            end
            p_ss = spi_ss; p_sck = spi_sck; p_mosi = spi_mosi;
        end
    end

    // Called at a falling clk edge; returns at the first IDLE sample.
    task automatic run_txn(input logic [23:0] a, input logic [23:0] nxt,
                           input int bp, input bit keep, input bit imm,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        int n;
        int hold_bad;
        logic [31:0] expw;
        logic [31:0] held;
        req_valid = 1'b1;
        req_addr  = a;
        n = 0;
        while (!req_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (imm) chk("first_idle_accept", n, 0);
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        fq.push_back(b0); fq.push_back(b1); fq.push_back(b2); fq.push_back(b3);
        expw = {b3, b2, b1, b0};
        resp_ready = (bp == 0);
        @(negedge clk);
        if (keep) req_addr = nxt;
        else req_valid = 1'b0;
        chk("start_busy_ss_ready", {busy, spi_ss, req_ready}, 3'b100);
        n = 1;
        while (!resp_valid && n < 300 * CLK_DIV + 20) begin
            @(negedge clk);
            n++;
            if (req_ready) early_acc++;
        end
        chk("latency", n, 1 + 128 * CLK_DIV);
        chk("resp_data", resp_data, expw);
        held = resp_data;
        if (bp > 0) begin
            hold_bad = 0;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                if (!resp_valid || resp_data !== held || req_ready || !spi_ss)
                    hold_bad++;
            end
            chk("backpressure_hold", hold_bad, 0);
            resp_ready = 1'b1;
        end
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_done", {resp_valid, busy, spi_ss}, 3'b011);
        n = 0;
        while (busy && n < CS_GAP + 50) begin
            n++;
            @(negedge clk);
        end
        chk("gap_len", n, CS_GAP);
        chk("idle_ready", req_ready, 1);
        if (capq.size() == 0) chk("mosi_capture", 0, 1);
        else chk("mosi_cmd_addr", capq.pop_front(), {8'h03, a});
    endtask

    initial begin
        logic [23:0] a;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {spi_ss, spi_sck, resp_valid, busy, spi_mosi}, 5'b10000);
        chk("rst_ready", req_ready, 0);
        chk("rst_data", resp_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", req_ready, 1);

        run_txn(24'h123456, 24'h0, 0, 0, 0, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
        run_txn(24'hA5C3F0, 24'h0, 10, 0, 0, 8'h11, 8'h22, 8'h33, 8'h44);

        run_txn(24'h000000, 24'hFFFFFF, 0, 1, 0, 8'h01, 8'h80, 8'h7F, 8'hFE);
        run_txn(24'hFFFFFF, 24'h0, 0, 0, 1, 8'hC3, 8'h3C, 8'h5A, 8'hA5);
        chk("b2b_ss_high", last_hi, CS_GAP + 2);

        req_valid = 1'b1;
        req_addr  = 24'h654321;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (37 * CLK_DIV) @(negedge clk);
        chk("abort_pre_sck", {spi_ss, spi_sck}, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_async", {spi_ss, spi_sck, busy, resp_valid, spi_mosi}, 5'b10000);
        repeat (3) @(negedge clk);
        chk("abort_no_resp", {resp_valid, req_ready}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", req_ready, 1);
        run_txn(24'h0ABCDE, 24'h0, 2, 0, 0, 8'h9A, 8'hBC, 8'hDE, 8'hF0);

        for (int t = 0; t < 10; t++) begin
            a = 24'($urandom);
            run_txn(a, 24'h0, int'($urandom_range(0, 4)), 0, 0,
                    8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        chk("no_early_accept", early_acc, 0);
        chk("sck_period", sck_bad, 0);
        chk("mosi_rules", mosi_bad, 0);
        chk("sck_count", win_bad, 0);
        chk("ss_gap_min", ss_bad, 0);
        chk("flash_bytes_used", fq.size(), 0);
        chk("capture_left", capq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got %0d expected 0", 1);
        $fatal(1);
    end
endmodule
